// File: rtl/upsample_pkg.sv
// Shared definitions for the nearest-neighbour 2x upsampler.
//   state_t         : row FSM encoding (live input row / replayed row)
//   DEF_DATA_WIDTH  : default pixel word width
//   cnt_width()     : counter width for a 0..n-1 counter, never narrower than 1 bit
package upsample_pkg;

  typedef enum logic {
    ST_ROW_LIVE   = 1'b0,
    ST_ROW_REPLAY = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;

  // A counter over 0..n-1 needs clog2(n) bits; n==1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_ram.sv
// One-row pixel buffer: DEPTH x DATA_WIDTH, one synchronous write port and
// one asynchronous read port, written so it maps onto distributed RAM.
//   clk      : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module row_ram #(
  parameter int DEPTH      = 13,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Contents are deliberately not reset: every entry is written in the live
  // row before it is read in the replay row.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsample_nearest_2x2.sv
// Nearest-neighbour 2x upsampler on a raster pixel stream. Every input pixel
// becomes a 2x2 block: each pixel of a live row is emitted twice as it
// arrives, and the whole row is then replayed (each pixel twice) from the
// row buffer, so a W x H frame becomes 2W x 2H.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   Data_In    : input pixel
//   Valid_In   : Data_In valid
//   In_Ready   : block can take a pixel this cycle (combinational from state)
//   Data_Out   : output pixel, registered
//   Valid_Out  : Data_Out valid, registered (downstream never stalls)
//   Frame_Done : one-cycle pulse with the last output pixel of a frame
//   Dbg_State  : current row FSM state (0 = live row, 1 = replay row)
//
// Handshake: a pixel is transferred in exactly the cycles where
// Valid_In & In_Ready is high. Valid_In while In_Ready is low is ignored and
// upstream must hold Data_In until it is taken. Valid_Out is not
// back-pressured; every cycle with Valid_Out high carries one output pixel.
module upsample_nearest_2x2
  import upsample_pkg::*;
#(
  parameter int IMG_WIDTH  = 13,
  parameter int IMG_HEIGHT = 13,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  In_Ready,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done,
  output logic                  Dbg_State
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign In_Ready = (state_q == ST_ROW_LIVE) & ~phase_q;
  assign accept   = Valid_In & In_Ready;

  // The same column counter addresses the write (live row) and the read
  // (replay row); the two never happen in the same state.
  row_ram #(
    .DEPTH      (IMG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (COL_W)
  ) u_row_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (col_q),
    .wdata_i (Data_In),
    .raddr_i (col_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ROW_LIVE;
      phase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ram_we  = 1'b0;

    unique case (state_q)
      ST_ROW_LIVE: begin
        if (!phase_q) begin
          if (accept) begin
            ram_we  = 1'b1;
            data_d  = Data_In;
            valid_d = 1'b1;
            phase_d = 1'b1;
          end
        end else begin
          // Second copy of the pixel: Data_Out simply holds. Leaving for the
          // replay row happens on this same cycle, so the copy is not lost.
          valid_d = 1'b1;
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_ROW_REPLAY;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      ST_ROW_REPLAY: begin
        data_d  = ram_rdata;
        valid_d = 1'b1;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (col_q == COL_LAST) begin
            // Last replay cycle: straight back to a live row, no idle cycle.
            col_d   = '0;
            state_d = ST_ROW_LIVE;
            if (row_q == ROW_LAST) begin
              row_d  = '0;
              done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_ROW_LIVE;
      end
    endcase
  end

  assign Data_Out   = data_q;
  assign Valid_Out  = valid_q;
  assign Frame_Done = done_q;
  assign Dbg_State  = state_q;

endmodule
